// File: rtl/axi4_lite_cmd_master_if.sv
// AXI4-Lite bundle shared between a command master and the CSR/RAM slave port.
interface axi4_lite_if #(
    parameter int ADDR_BIT_WIDTH = 8,
    parameter int DATA_BIT_WIDTH = 32
);
    logic                          awvalid;
    logic                          awready;
    logic [ADDR_BIT_WIDTH-1:0]     awaddr;
    logic [2:0]                    awprot;
    logic                          wvalid;
    logic                          wready;
    logic [DATA_BIT_WIDTH-1:0]     wdata;
    logic [DATA_BIT_WIDTH/8-1:0]   wstrb;
    logic                          bvalid;
    logic                          bready;
    logic [1:0]                    bresp;
    logic                          arvalid;
    logic                          arready;
    logic [ADDR_BIT_WIDTH-1:0]     araddr;
    logic [2:0]                    arprot;
    logic                          rvalid;
    logic                          rready;
    logic [DATA_BIT_WIDTH-1:0]     rdata;
    logic [1:0]                    rresp;

    modport mst_port (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slv_port (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding command/response to AXI4-Lite master bridge with a response
// timeout; a timed-out transaction is drained off the bus before the next command.
//
// state   | meaning
// IDLE    | o_cmd_ready high, waiting for a command
// WR      | awvalid/wvalid pending, each drops after its own handshake
// WR_RESP | bready high, waiting for bvalid
// RD_ADDR | arvalid high, waiting for arready
// RD_DATA | rready high, waiting for rvalid
// RSP     | o_rsp_valid high until i_rsp_ready
// DRAIN   | timed-out transaction still owes handshakes; result discarded
module axi4_lite_cmd_master #(
    parameter int ADDR_BIT_WIDTH = 8,
    parameter int DATA_BIT_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        i_clk,
    input  logic                        i_sync_rst,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_ready,
    input  logic                        i_cmd_is_wr,
    input  logic [ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
    input  logic [DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
    output logic                        o_rsp_valid,
    input  logic                        i_rsp_ready,
    output logic [DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
    output logic [1:0]                  o_rsp_resp,
    output logic                        o_rsp_timeout,
    axi4_lite_if.mst_port               if_m_axi4_lite
);

    localparam int STRB_W  = DATA_BIT_WIDTH / 8;
    localparam int ALIGN_W = $clog2(STRB_W);
    localparam int CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]          TMO_LIM   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [ADDR_BIT_WIDTH-1:0] ADDR_MASK = {ADDR_BIT_WIDTH{1'b1}} << ALIGN_W;

    generate
        if (DATA_BIT_WIDTH != 32 && DATA_BIT_WIDTH != 64) begin : g_bad_width
            $error("axi4_lite_cmd_master: DATA_BIT_WIDTH must be 32 or 64");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP, DRAIN
    } state_t;

    state_t                      state_q, state_d;
    logic                        cmd_ready_q, cmd_ready_d;
    logic                        is_wr_q, is_wr_d;
    logic                        owe_q, owe_d;
    logic [ADDR_BIT_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_BIT_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]           wstrb_q, wstrb_d;
    logic                        awvalid_q, awvalid_d;
    logic                        wvalid_q, wvalid_d;
    logic                        bready_q, bready_d;
    logic                        arvalid_q, arvalid_d;
    logic                        rready_q, rready_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic [DATA_BIT_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                  rsp_resp_q, rsp_resp_d;
    logic                        rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic accept, tmo_hit;
    logic [CNT_W-1:0] cnt_inc;

    assign aw_hs   = awvalid_q & if_m_axi4_lite.awready;
    assign w_hs    = wvalid_q  & if_m_axi4_lite.wready;
    assign b_hs    = bready_q  & if_m_axi4_lite.bvalid;
    assign ar_hs   = arvalid_q & if_m_axi4_lite.arready;
    assign r_hs    = rready_q  & if_m_axi4_lite.rvalid;
    assign accept  = i_cmd_valid & cmd_ready_q;
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign tmo_hit = (TIMEOUT_CYCLES > 0) && (cnt_inc == TMO_LIM);

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = 1'b0;
        is_wr_d       = is_wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        // Valid/ready tracking is state-independent so that a timed-out
        // transaction keeps honouring the bus through RSP and DRAIN.
        awvalid_d     = awvalid_q & ~aw_hs;
        wvalid_d      = wvalid_q  & ~w_hs;
        arvalid_d     = arvalid_q & ~ar_hs;
        owe_d         = owe_q & ~(b_hs | r_hs);
        bready_d      = is_wr_q  & owe_d & ~awvalid_d & ~wvalid_d;
        rready_d      = ~is_wr_q & owe_d & ~arvalid_d;

        if (state_q inside {WR, WR_RESP, RD_ADDR, RD_DATA}) begin
            cnt_d = cnt_inc;
        end

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (accept) begin
                    cmd_ready_d = 1'b0;
                    is_wr_d     = i_cmd_is_wr;
                    addr_d      = i_cmd_addr & ADDR_MASK;
                    wdata_d     = i_cmd_wdata;
                    wstrb_d     = i_cmd_wstrb;
                    cnt_d       = '0;
                    owe_d       = 1'b1;
                    awvalid_d   = i_cmd_is_wr;
                    wvalid_d    = i_cmd_is_wr;
                    arvalid_d   = ~i_cmd_is_wr;
                    bready_d    = 1'b0;
                    rready_d    = 1'b0;
                    state_d     = i_cmd_is_wr ? WR : RD_ADDR;
                end
            end
            WR: begin
                if (tmo_hit) begin
                    state_d = RSP;
                end else if (!awvalid_d && !wvalid_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_d     = RSP;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = if_m_axi4_lite.bresp;
                end else if (tmo_hit) begin
                    state_d = RSP;
                end
            end
            RD_ADDR: begin
                if (tmo_hit) begin
                    state_d = RSP;
                end else if (ar_hs) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    state_d     = RSP;
                    rsp_rdata_d = if_m_axi4_lite.rdata;
                    rsp_resp_d  = if_m_axi4_lite.rresp;
                end else if (tmo_hit) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_timeout_q) begin
                        state_d = DRAIN;
                    end else begin
                        state_d     = IDLE;
                        cmd_ready_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!owe_d) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Entry into RSP from an active state: a timeout when no final
        // handshake claimed the transition above.
        if (state_d == RSP && state_q != RSP) begin
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = owe_d;
            if (owe_d) begin
                rsp_rdata_d = '0;
                rsp_resp_d  = 2'b10;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            is_wr_q       <= 1'b0;
            owe_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            is_wr_q       <= is_wr_d;
            owe_q         <= owe_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign o_cmd_ready   = cmd_ready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_resp    = rsp_resp_q;
    assign o_rsp_timeout = rsp_timeout_q;

    assign if_m_axi4_lite.awvalid = awvalid_q;
    assign if_m_axi4_lite.awaddr  = addr_q;
    assign if_m_axi4_lite.awprot  = 3'b000;
    assign if_m_axi4_lite.wvalid  = wvalid_q;
    assign if_m_axi4_lite.wdata   = wdata_q;
    assign if_m_axi4_lite.wstrb   = wstrb_q;
    assign if_m_axi4_lite.bready  = bready_q;
    assign if_m_axi4_lite.arvalid = arvalid_q;
    assign if_m_axi4_lite.araddr  = addr_q;
    assign if_m_axi4_lite.arprot  = 3'b000;
    assign if_m_axi4_lite.rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Directed bench for axi4_lite_cmd_master: the bench plays the AXI slave by hand
// and compares every observed value against hand-computed expectations.
module tb_axi4_lite_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_is_wr;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    int n_total = 0;
    int n_bad   = 0;

    axi4_lite_if #(.ADDR_BIT_WIDTH(8), .DATA_BIT_WIDTH(32)) axi ();

    axi4_lite_cmd_master #(
        .ADDR_BIT_WIDTH(8),
        .DATA_BIT_WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk          (clk),
        .i_sync_rst     (rst),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_is_wr    (cmd_is_wr),
        .i_cmd_addr     (cmd_addr),
        .i_cmd_wdata    (cmd_wdata),
        .i_cmd_wstrb    (cmd_wstrb),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_resp     (rsp_resp),
        .o_rsp_timeout  (rsp_timeout),
        .if_m_axi4_lite (axi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        chk("cmd_ready_pre", 64'(cmd_ready), 64'h1);
        cmd_valid = 1'b1; cmd_is_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        step();
        cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_is_wr = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;

        // reset state
        repeat (3) step();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_awvalid",   64'(axi.awvalid), 64'h0);
        chk("rst_arvalid",   64'(axi.arvalid), 64'h0);
        chk("rst_awaddr",    64'(axi.awaddr), 64'h0);
        chk("rst_rdata",     64'(rsp_rdata), 64'h0);
        chk("awprot",        64'(axi.awprot), 64'h0);
        rst = 1'b0;
        step();
        chk("idle_ready", 64'(cmd_ready), 64'h1);

        // write, slave always ready
        axi.awready = 1'b1; axi.wready = 1'b1;
        issue(1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF);
        chk("w1_awvalid", 64'(axi.awvalid), 64'h1);
        chk("w1_wvalid",  64'(axi.wvalid), 64'h1);
        chk("w1_awaddr",  64'(axi.awaddr), 64'h04);
        chk("w1_wdata",   64'(axi.wdata), 64'hDEAD_BEEF);
        chk("w1_wstrb",   64'(axi.wstrb), 64'hF);
        chk("w1_ready0",  64'(cmd_ready), 64'h0);
        step();
        chk("w1_awdrop",  64'(axi.awvalid), 64'h0);
        chk("w1_wdrop",   64'(axi.wvalid), 64'h0);
        chk("w1_bready",  64'(axi.bready), 64'h1);
        axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bvalid = 1'b1; axi.bresp = 2'b00;
        step();
        axi.bvalid = 1'b0;
        chk("w1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("w1_resp",      64'(rsp_resp), 64'h0);
        chk("w1_timeout",   64'(rsp_timeout), 64'h0);
        chk("w1_rdata",     64'(rsp_rdata), 64'h0);
        chk("w1_bready0",   64'(axi.bready), 64'h0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("w1_rsp_done", 64'(rsp_valid), 64'h0);
        chk("w1_ready1",   64'(cmd_ready), 64'h1);

        // read of unaligned 0x0B, data after 5 cycles, then 10-cycle response stall
        axi.arready = 1'b1;
        issue(1'b0, 8'h0B, 32'h0, 4'h0);
        chk("r1_arvalid", 64'(axi.arvalid), 64'h1);
        chk("r1_araddr",  64'(axi.araddr), 64'h08);
        chk("r1_rready0", 64'(axi.rready), 64'h0);
        step();
        axi.arready = 1'b0;
        chk("r1_ardrop",  64'(axi.arvalid), 64'h0);
        chk("r1_rready",  64'(axi.rready), 64'h1);
        repeat (4) step();
        chk("r1_wait", 64'(rsp_valid), 64'h0);
        axi.rvalid = 1'b1; axi.rdata = 32'h1234_5678; axi.rresp = 2'b00;
        step();
        axi.rvalid = 1'b0; axi.rdata = 32'h0;
        chk("r1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("r1_rdata",     64'(rsp_rdata), 64'h1234_5678);
        chk("r1_resp",      64'(rsp_resp), 64'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_valid", 64'(rsp_valid), 64'h1);
            chk("stall_rdata", 64'(rsp_rdata), 64'h1234_5678);
            chk("stall_ready", 64'(cmd_ready), 64'h0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("r1_rsp_done", 64'(rsp_valid), 64'h0);
        chk("r1_ready1",   64'(cmd_ready), 64'h1);

        // write: awready 3 cycles before wready; early bvalid is held off
        issue(1'b1, 8'h10, 32'hA5A5_0F0F, 4'h3);
        chk("w2_awvalid", 64'(axi.awvalid), 64'h1);
        chk("w2_wvalid",  64'(axi.wvalid), 64'h1);
        axi.awready = 1'b1;
        step();
        axi.awready = 1'b0;
        axi.bvalid = 1'b1; axi.bresp = 2'b10;
        chk("w2_awdrop",  64'(axi.awvalid), 64'h0);
        chk("w2_whold",   64'(axi.wvalid), 64'h1);
        chk("w2_bready0", 64'(axi.bready), 64'h0);
        repeat (2) step();
        chk("w2_whold3",  64'(axi.wvalid), 64'h1);
        chk("w2_wdata",   64'(axi.wdata), 64'hA5A5_0F0F);
        chk("w2_wstrb",   64'(axi.wstrb), 64'h3);
        chk("w2_bready0b", 64'(axi.bready), 64'h0);
        chk("w2_norsp",   64'(rsp_valid), 64'h0);
        axi.wready = 1'b1;
        step();
        axi.wready = 1'b0;
        chk("w2_wdrop",  64'(axi.wvalid), 64'h0);
        chk("w2_bready", 64'(axi.bready), 64'h1);
        chk("w2_norsp2", 64'(rsp_valid), 64'h0);
        step();
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
        chk("w2_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("w2_resp",      64'(rsp_resp), 64'h2);
        chk("w2_timeout",   64'(rsp_timeout), 64'h0);
        chk("w2_rdata",     64'(rsp_rdata), 64'h0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
        chk("w2_single_rsp", 64'(rsp_valid), 64'h0);

        // read timeout at 16 cycles, then drain of a late rvalid
        axi.arready = 1'b1;
        issue(1'b0, 8'h20, 32'h0, 4'h0);
        for (int i = 1; i <= 15; i++) begin
            step();
            if (i == 1) axi.arready = 1'b0;
        end
        chk("to_rready",   64'(axi.rready), 64'h1);
        chk("to_not_yet",  64'(rsp_valid), 64'h0);
        step();
        chk("to_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("to_timeout",   64'(rsp_timeout), 64'h1);
        chk("to_resp",      64'(rsp_resp), 64'h2);
        chk("to_rdata",     64'(rsp_rdata), 64'h0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("dr_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("dr_ready0",    64'(cmd_ready), 64'h0);
        chk("dr_rready",    64'(axi.rready), 64'h1);
        repeat (2) step();
        chk("dr_rready2",   64'(axi.rready), 64'h1);
        chk("dr_ready0b",   64'(cmd_ready), 64'h0);
        axi.rvalid = 1'b1; axi.rdata = 32'h0000_0BAD;
        step();
        axi.rvalid = 1'b0; axi.rdata = 32'h0;
        chk("dr_ready1",    64'(cmd_ready), 64'h1);
        chk("dr_discard",   64'(rsp_valid), 64'h0);
        chk("dr_rready0",   64'(axi.rready), 64'h0);

        // reset while a write is pending
        issue(1'b1, 8'h44, 32'h1111_2222, 4'hF);
        chk("rw_awvalid", 64'(axi.awvalid), 64'h1);
        rst = 1'b1;
        step();
        chk("rw_awvalid0", 64'(axi.awvalid), 64'h0);
        chk("rw_wvalid0",  64'(axi.wvalid), 64'h0);
        chk("rw_awaddr0",  64'(axi.awaddr), 64'h0);
        chk("rw_wdata0",   64'(axi.wdata), 64'h0);
        chk("rw_ready0",   64'(cmd_ready), 64'h0);
        chk("rw_rsp0",     64'(rsp_valid), 64'h0);
        rst = 1'b0;
        step();
        axi.arready = 1'b1;
        issue(1'b0, 8'h33, 32'h0, 4'h0);
        chk("pr_araddr", 64'(axi.araddr), 64'h30);
        step();
        axi.arready = 1'b0;
        axi.rvalid = 1'b1; axi.rdata = 32'hCAFE_F00D; axi.rresp = 2'b00;
        step();
        axi.rvalid = 1'b0; axi.rdata = 32'h0;
        chk("pr_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("pr_rdata",     64'(rsp_rdata), 64'hCAFE_F00D);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("pr_ready1", 64'(cmd_ready), 64'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
